mdu_hilo: RTL and testbench

- Multiply/divide unit in the execute stage, directly downstream of the general register file.
- Consumes the rs/rt read data and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO into private HI/LO registers.
- Models multi-cycle latency with a busy counter; the pipeline controller stalls on busy.
- HI/LO outputs feed MFHI/MFLO writeback into the register file.

---
 rtl/mdu_hilo.sv | 154 +++++++++++++++
 tb/tb_mdu_hilo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with private HI/LO registers and a fixed-latency busy window.
// Define MDU_MADD_EN to enable op=111 (MADD: {HI,LO} += signed A*B); otherwise op=111 is a no-op.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b111;
`endif

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] pend_hi_reg, pend_hi_next;
    logic [31:0] pend_lo_reg, pend_lo_next;
    logic        pend_ok_reg, pend_ok_next;

    // Products: low 64 bits of the sign-extended product equal the signed product.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

`ifdef MDU_MADD_EN
    logic [63:0] madd_sum;
    assign madd_sum = {hi_reg, lo_reg} + prod_s;
`endif

    // One unsigned divider serves both DIV and DIVU via sign-magnitude conversion;
    // this also yields 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    assign div_signed = (op == OP_DIV);
    assign a_neg  = div_signed & A[31];
    assign b_neg  = div_signed & B[31];
    assign a_mag  = a_neg ? (~A + 32'd1) : A;
    assign b_mag  = b_neg ? (~B + 32'd1) : B;
    assign b_safe = (B == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 5'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            pend_ok_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_ok_reg <= pend_ok_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_ok_next = pend_ok_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {pend_hi_next, pend_lo_next} = prod_s;
                            pend_ok_next = 1'b1;
                            cnt_next     = MULT_N;
                            state_next   = RUN;
                        end
                        OP_MULTU: begin
                            {pend_hi_next, pend_lo_next} = prod_u;
                            pend_ok_next = 1'b1;
                            cnt_next     = MULT_N;
                            state_next   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_next = rem;
                            pend_lo_next = quot;
                            // Divide by zero still burns the full latency but never commits.
                            pend_ok_next = (B != 32'd0);
                            cnt_next     = DIV_N;
                            state_next   = RUN;
                        end
                        OP_MTHI: hi_next = A;
                        OP_MTLO: lo_next = A;
`ifdef MDU_MADD_EN
                        OP_MADD: begin
                            {pend_hi_next, pend_lo_next} = madd_sum;
                            pend_ok_next = 1'b1;
                            cnt_next     = MULT_N;
                            state_next   = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_reg == 5'd1) begin
                    state_next   = IDLE;
                    cnt_next     = 5'd0;
                    pend_ok_next = 1'b0;
                    if (pend_ok_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed, table-driven bench for mdu_hilo with hand sequences for busy/reset corners.
module tb_mdu_hilo;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .HI    (hi),
        .LO    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    localparam int NV = 17;
    vec_t vec [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input int t_n,
                          input string nm);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < t_n; i++) begin
            @(negedge clk);
            check({nm, " busy"}, {31'd0, busy}, 32'd1);
            check({nm, " hi_hold"}, hi, model_hi);
            check({nm, " lo_hold"}, lo, model_lo);
        end
        @(negedge clk);
        check({nm, " busy_end"}, {31'd0, busy}, 32'd0);
        check({nm, " hi"}, hi, e_hi);
        check({nm, " lo"}, lo, e_lo);
        model_hi = e_hi;
        model_lo = e_lo;
        $display("txn %-8s op=%0d A=%08h B=%08h -> HI=%08h LO=%08h", nm, t_op, t_a, t_b, hi, lo);
    endtask

    initial begin
        vec[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vec[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vec[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vec[3]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vec[4]  = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, 10};
        vec[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vec[6]  = '{3'd5, 32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000, 0};
        vec[7]  = '{3'd6, 32'h0000ABCD, 32'h00000000, 32'h12345678, 32'h0000ABCD, 0};
        vec[8]  = '{3'd4, 32'h00000064, 32'h00000000, 32'h12345678, 32'h0000ABCD, 10};
        vec[9]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vec[10] = '{3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};
        vec[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vec[12] = '{3'd2, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 5};
        vec[13] = '{3'd0, 32'hDEADBEEF, 32'h00000001, 32'h00000001, 32'h00000000, 0};
        vec[14] = '{3'd5, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 0};
        vec[15] = '{3'd6, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000005, 0};
`ifdef MDU_MADD_EN
        vec[16] = '{3'd7, 32'h00000002, 32'h00000003, 32'h00000000, 32'h0000000B, 5};
`else
        vec[16] = '{3'd7, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000005, 0};
`endif

        reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < NV; v++) begin
            run_op(vec[v].op, vec[v].a, vec[v].b, vec[v].hi, vec[v].lo, vec[v].n,
                   $sformatf("vec%0d", v));
        end

        // MTHI during a MULT busy window is dropped; the MULT still commits.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("ign busy", {31'd0, busy}, 32'd1);
            if (i == 2) begin
                start = 1'b1; op = 3'd5; a = 32'h00001234;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        @(negedge clk);
        check("ign busy_end", {31'd0, busy}, 32'd0);
        check("ign hi", hi, 32'd0);
        check("ign lo", lo, 32'h0000000C);
        $display("txn ignore   MULT 3*4 with MTHI while busy -> HI=%08h LO=%08h", hi, lo);

        // A start presented at the commit edge is still ignored.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("cedge busy", {31'd0, busy}, 32'd1);
            if (i == 5) begin
                start = 1'b1; op = 3'd6; a = 32'h00005555;
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("cedge busy_end", {31'd0, busy}, 32'd0);
        check("cedge hi", hi, 32'd0);
        check("cedge lo", lo, 32'h00000004);
        $display("txn commit   MULT 2*2 with MTLO at commit edge -> HI=%08h LO=%08h", hi, lo);

        // Asynchronous reset in the middle of a DIV.
        run_op(3'd5, 32'h0000BEEF, 32'd0, 32'h0000BEEF, 32'h00000004, 0, "mthi");
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("arst pre busy", {31'd0, busy}, 32'd1);
        end
        #2 reset = 1'b0;
        #1;
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst hi", hi, 32'd0);
        check("arst lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("arst post busy", {31'd0, busy}, 32'd0);
        check("arst post hi", hi, 32'd0);
        check("arst post lo", lo, 32'd0);
        $display("txn reset    DIV 100/7 aborted by reset -> HI=%08h LO=%08h", hi, lo);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
